video_dram_port: RTL
====================

Name: video_dram_port

Overview:
- Memory-arbiter end of the video fetch port.
- Answers the video fetch engine's video_go/video_addr/video_bw requests with video_next and video_strobe/video_data.
- Divides DRAM cycles between video and CPU using a repeating 8-slot bandwidth pattern.
- Issues each granted cycle to the DRAM controller and routes the returned read data back to its requester.

Parameters:
- TAGQ_DEPTH, 2: maximum number of outstanding read cycles awaiting dram_rdy.
- AW, 21: address width (word address).

Ports:
- clk  in  1  28 MHz clock
- rst  in  1  synchronous active-high reset
- pre_cend  in  1  one clk before DRAM cycle end; arbitration sample point
- cend  in  1  DRAM cycle boundary strobe
- frame_sync  in  1  realign slot counter; slot becomes 0 at next cend
- video_go  in  1  video requests bandwidth
- video_bw  in  2  00=1/8, 01=1/4, 10=1/2, 11=full
- video_addr  in  AW  video fetch address
- video_next  out  1  pulse: video_addr consumed, advance address
- video_strobe  out  1  pulse: video_data valid
- video_data  out  16  fetched word
- cpu_req  in  1  CPU cycle request
- cpu_rnw  in  1  1=read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  16  write data
- cpu_wsel  in  2  byte-lane select
- cpu_next  out  1  pulse: CPU request accepted
- cpu_strobe  out  1  pulse: cpu_rdata valid
- cpu_rdata  out  16  read data
- dram_go  out  1  pulse: start DRAM cycle
- dram_rnw  out  1  cycle direction
- dram_addr  out  AW  cycle address
- dram_wdata  out  16  write data
- dram_wsel  out  2  byte lanes
- dram_rdata  in  16  read data
- dram_rdy  in  1  pulse: dram_rdata valid for oldest read
- err  out  1  sticky: dram_rdy arrived with no outstanding read

Behaviour:
- Reset: every output is 0. Slot counter = 0. Tag queue empty. Pending realign cleared. In-flight reads are discarded.
- Slot counter (3 bits) increments on each cend and wraps 7->0.
- frame_sync sets pending_realign. At the next cend the counter loads 0 instead of incrementing, and the flag clears. If frame_sync and cend coincide, the counter loads 0 on that same cend.
- Video slot allowed by video_bw:
  - 00: slot 0.
  - 01: slots 0 and 4.
  - 10: even slots.
  - 11: all slots.
- Arbitration happens on the clk edge where pre_cend=1, using the current slot value:
  - video_go=1 and slot allowed -> video read.
  - else cpu_req=1 -> CPU cycle.
  - else idle.
- Read grants (video, or CPU with cpu_rnw=1) require a free tag entry, where "free" accounts for a dram_rdy pop in the same clk. If no entry is free, the slot becomes idle and the CPU is not considered.
- Grant registration: in the clk where cend=1, the following pulse for exactly one clk:
  - dram_go, plus video_next or cpu_next.
  - dram_addr/dram_rnw/dram_wdata/dram_wsel are driven from the request latched at pre_cend and hold until the next grant.
  - A read pushes a tag (0=video, 1=cpu) in that same clk.
  - Video grants always have dram_rnw=1.
  - A CPU write pushes no tag.
- Requests must hold stable from pre_cend through cend. A change between them is ignored; the pre_cend sample wins.
- Return path: on dram_rdy, pop the oldest tag. In the next clk, the tag's strobe (video_strobe or cpu_strobe) pulses, with video_data/cpu_rdata = registered dram_rdata. Each data output holds until its next strobe. Latency is 1 clk from dram_rdy.
- Simultaneous push and pop in one clk: both occur and occupancy is unchanged. Order is preserved.
- dram_rdy with an empty queue: ignored, err set to 1 until rst.
- Idle slot: no pulses; dram_* outputs hold their values.

Decomposition:
- Package video_port_pkg: bw encodings, tag values (TAG_VID=0, TAG_CPU=1), slot-mask function slot_allowed(bw, slot).
- Sub-module video_port_tagq: TAGQ_DEPTH-deep 1-bit FIFO with push, pop, full, empty, same-cycle push/pop.

Test Plan:
- bw=00, video_go=1 constant, cpu_req=0, dram_rdy 2 clk after each dram_go, for 16 DRAM cycles -> video_next at slots 0 only (2 pulses). Each video_strobe comes 1 clk after dram_rdy, with data 16'hA5A5 echoed.
- bw=01, video_go=1, cpu_req=1 read throughout -> video in slots 0,4; CPU in the other 6 of every 8. cpu_strobe count 6 and video_strobe count 2 per 8 cycles, in order.
- Fill the queue: bw=11, dram_rdy withheld -> 2 dram_go, third slot idle (no dram_go/video_next). One dram_rdy then frees one grant at the next pre_cend.
- frame_sync asserted at slot 5 with bw=00 -> the next cend sets slot 0 and a video grant occurs in that cycle; the counter then runs 1,2,...
- CPU write (wdata 16'h1234, wsel 2'b10) in a non-video slot -> dram_go with dram_rnw=0 and matching data/lanes, no tag push, no cpu_strobe.
- rst asserted with 2 reads outstanding, then dram_rdy pulse -> outputs 0, no strobe, err=1 and stays 1.

Source files
------------

// File: rtl/video_port_pkg.sv
// rtl/video_port_pkg.sv - shared encodings and slot-mask helper for the video DRAM port
package video_port_pkg;

  localparam logic [1:0] BW_EIGHTH  = 2'b00;
  localparam logic [1:0] BW_QUARTER = 2'b01;
  localparam logic [1:0] BW_HALF    = 2'b10;
  localparam logic [1:0] BW_FULL    = 2'b11;

  localparam logic TAG_VID = 1'b0;
  localparam logic TAG_CPU = 1'b1;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  // Which of the 8 repeating slots video may claim at a given bandwidth.
  function automatic logic slot_allowed(input logic [1:0] bw, input logic [2:0] slot);
    logic ok;
    ok = 1'b0;
    case (bw)
      BW_EIGHTH:  ok = (slot == 3'd0);
      BW_QUARTER: ok = (slot[1:0] == 2'd0);
      BW_HALF:    ok = ~slot[0];
      BW_FULL:    ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/video_port_tagq.sv
// rtl/video_port_tagq.sv - small FIFO of 1-bit requester tags for outstanding reads
module video_port_tagq #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same clk frees the slot a full-queue push needs.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_tag = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_dram_port.sv
// rtl/video_dram_port.sv - slot-based video/CPU arbiter in front of the DRAM controller
module video_dram_port
  import video_port_pkg::*;
#(
  parameter int TAGQ_DEPTH = 2,
  parameter int AW         = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pre_cend,
  input  logic          cend,
  input  logic          frame_sync,
  input  logic          video_go,
  input  logic [1:0]    video_bw,
  input  logic [AW-1:0] video_addr,
  output logic          video_next,
  output logic          video_strobe,
  output logic [15:0]   video_data,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic [1:0]    cpu_wsel,
  output logic          cpu_next,
  output logic          cpu_strobe,
  output logic [15:0]   cpu_rdata,
  output logic          dram_go,
  output logic          dram_rnw,
  output logic [AW-1:0] dram_addr,
  output logic [15:0]   dram_wdata,
  output logic [1:0]    dram_wsel,
  input  logic [15:0]   dram_rdata,
  input  logic          dram_rdy,
  output logic          err
);

  logic [2:0]    slot;
  logic          realign_pend;
  gnt_e          gnt;
  gnt_e          pend_kind;
  logic [AW-1:0] pend_addr;
  logic          pend_rnw;
  logic [15:0]   pend_wdata;
  logic [1:0]    pend_wsel;
  logic          tag_free;
  logic          tq_push;
  logic          tq_push_tag;
  logic          tq_head;
  logic          tq_full;
  logic          tq_empty;
  logic          rdy_vid;
  logic          rdy_cpu;

  // A full queue still has room if a dram_rdy pops it in this same clk.
  assign tag_free    = !tq_full || dram_rdy;
  assign tq_push     = cend && (pend_kind != GNT_IDLE) && pend_rnw;
  assign tq_push_tag = (pend_kind == GNT_CPU) ? TAG_CPU : TAG_VID;
  assign rdy_vid     = dram_rdy && !tq_empty && (tq_head == TAG_VID);
  assign rdy_cpu     = dram_rdy && !tq_empty && (tq_head == TAG_CPU);

  video_port_tagq #(.DEPTH(TAGQ_DEPTH)) u_tagq (
    .clk      (clk),
    .rst      (rst),
    .push     (tq_push),
    .push_tag (tq_push_tag),
    .pop      (dram_rdy),
    .head_tag (tq_head),
    .full     (tq_full),
    .empty    (tq_empty)
  );

  // Slot decision: an allowed video slot is never handed to the CPU, even if it goes idle.
  always_comb begin
    gnt = GNT_IDLE;
    if (video_go && slot_allowed(video_bw, slot)) begin
      if (tag_free) gnt = GNT_VID;
    end else if (cpu_req && (!cpu_rnw || tag_free)) begin
      gnt = GNT_CPU;
    end
  end

  // Slot counter; a frame_sync forces the next cend to restart the pattern at slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot         <= 3'd0;
      realign_pend <= 1'b0;
    end else if (cend) begin
      slot         <= (realign_pend || frame_sync) ? 3'd0 : slot + 3'd1;
      realign_pend <= 1'b0;
    end else if (frame_sync) begin
      realign_pend <= 1'b1;
    end
  end

  // Capture the winning request at pre_cend; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_kind  <= GNT_IDLE;
      pend_addr  <= '0;
      pend_rnw   <= 1'b0;
      pend_wdata <= '0;
      pend_wsel  <= '0;
    end else if (pre_cend) begin
      pend_kind  <= gnt;
      pend_addr  <= (gnt == GNT_VID) ? video_addr : cpu_addr;
      pend_rnw   <= (gnt == GNT_VID) ? 1'b1 : cpu_rnw;
      pend_wdata <= (gnt == GNT_VID) ? 16'h0000 : cpu_wdata;
      pend_wsel  <= (gnt == GNT_VID) ? 2'b00 : cpu_wsel;
    end else if (cend) begin
      pend_kind  <= GNT_IDLE;
    end
  end

  // Issue the captured cycle at cend; the dram_* fields hold across idle slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      dram_go    <= 1'b0;
      video_next <= 1'b0;
      cpu_next   <= 1'b0;
      dram_rnw   <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wsel  <= '0;
    end else begin
      dram_go    <= 1'b0;
      video_next <= 1'b0;
      cpu_next   <= 1'b0;
      if (cend && (pend_kind != GNT_IDLE)) begin
        dram_go    <= 1'b1;
        video_next <= (pend_kind == GNT_VID);
        cpu_next   <= (pend_kind == GNT_CPU);
        dram_rnw   <= pend_rnw;
        dram_addr  <= pend_addr;
        dram_wdata <= pend_wdata;
        dram_wsel  <= pend_wsel;
      end
    end
  end

  // Route returned read data to the requester named by the oldest tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      video_strobe <= 1'b0;
      cpu_strobe   <= 1'b0;
      video_data   <= '0;
      cpu_rdata    <= '0;
      err          <= 1'b0;
    end else begin
      video_strobe <= rdy_vid;
      cpu_strobe   <= rdy_cpu;
      if (rdy_vid) video_data <= dram_rdata;
      if (rdy_cpu) cpu_rdata  <= dram_rdata;
      if (dram_rdy && tq_empty) err <= 1'b1;
    end
  end

endmodule
